// File: rtl/regfile_scoreboard_if.sv
// Register-file bus between the control unit (master) and the register file (slave):
// two read ports, main and link write ports, and the issue/scoreboard handshake.
interface regfile_scoreboard_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4
);
   logic              flush;
   logic [ADDR_W-1:0] ra_addr;
   logic [ADDR_W-1:0] rb_addr;
   logic              ra_baout;
   logic              rb_baout;
   logic [DATA_W-1:0] ra_data;
   logic [DATA_W-1:0] rb_data;
   logic              ra_busy;
   logic              rb_busy;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              link_en;
   logic [DATA_W-1:0] link_data;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_addr;
   logic              issue_ready;
   logic [ADDR_W:0]   busy_count;

   modport master (
      output flush, ra_addr, rb_addr, ra_baout, rb_baout, wr_en, wr_addr, wr_data,
             link_en, link_data, issue_valid, issue_addr,
      input  ra_data, rb_data, ra_busy, rb_busy, issue_ready, busy_count
   );

   modport slave (
      input  flush, ra_addr, rb_addr, ra_baout, rb_baout, wr_en, wr_addr, wr_data,
             link_en, link_data, issue_valid, issue_addr,
      output ra_data, rb_data, ra_busy, rb_busy, issue_ready, busy_count
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Mini-SRC register file: two write-first bypassed read ports, main + link write ports and a
// busy-bit scoreboard that holds off issue while a multi-cycle result is pending.
module regfile_scoreboard #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_REGS  = 16,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned ZERO_MODE = 1,
   parameter int unsigned LINK_REG  = 15
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   regfile_scoreboard_if.slave io_bus
);

   localparam int unsigned       CntW     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;
   logic [CntW-1:0]     r_busy_cnt;

   logic [DATA_W-1:0]   w_regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] w_busy_d;
   logic [CntW-1:0]     w_busy_cnt_d;
   logic                w_issue_ready;
   logic                w_issue_ok;
   logic [ADDR_W-1:0]   w_rd_addr  [2];
   logic                w_rd_baout [2];
   logic [DATA_W-1:0]   w_rd_data  [2];
   logic                w_rd_busy  [2];

   function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < NUM_REGS;
   endfunction

   // Registers that hold data and can be reserved; a hardwired R0 is neither.
   function automatic logic f_storable(input logic [ADDR_W-1:0] a);
      return f_in_range(a) && !(ZERO_MODE == 2 && a == '0);
   endfunction

   function automatic logic f_zero_override(input logic [ADDR_W-1:0] a, input logic baout);
      return (a == '0) && (ZERO_MODE == 2 || (ZERO_MODE == 1 && baout));
   endfunction

   function automatic logic f_wr_hit(input logic [ADDR_W-1:0] a, input logic wr_en,
                                     input logic [ADDR_W-1:0] wr_addr, input logic link_en);
      return (wr_en && wr_addr == a) || (link_en && a == LinkAddr);
   endfunction

   assign w_rd_addr[0]  = io_bus.ra_addr;
   assign w_rd_addr[1]  = io_bus.rb_addr;
   assign w_rd_baout[0] = io_bus.ra_baout;
   assign w_rd_baout[1] = io_bus.rb_baout;

   // Read ports: link bypass beats main-write bypass beats storage; R0 override applied last.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rd_data[p] = '0;
         w_rd_busy[p] = 1'b0;
         if (f_in_range(w_rd_addr[p]) && !f_zero_override(w_rd_addr[p], w_rd_baout[p])) begin
            if (io_bus.link_en && w_rd_addr[p] == LinkAddr) begin
               w_rd_data[p] = io_bus.link_data;
            end else if (io_bus.wr_en && io_bus.wr_addr == w_rd_addr[p]) begin
               w_rd_data[p] = io_bus.wr_data;
            end else begin
               w_rd_data[p] = r_regs[w_rd_addr[p]];
            end
            w_rd_busy[p] = r_busy[w_rd_addr[p]] &&
                           !f_wr_hit(w_rd_addr[p], io_bus.wr_en, io_bus.wr_addr, io_bus.link_en);
         end
      end
   end

   // A writeback landing this cycle frees the destination for a new reservation.
   always_comb begin
      w_issue_ready = 1'b1;
      if (f_in_range(io_bus.issue_addr)) begin
         w_issue_ready = !r_busy[io_bus.issue_addr] ||
                         f_wr_hit(io_bus.issue_addr, io_bus.wr_en, io_bus.wr_addr, io_bus.link_en);
      end
   end

   assign w_issue_ok = io_bus.issue_valid && w_issue_ready && !io_bus.flush;

   always_comb begin
      w_busy_cnt_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_regs_d[i] = r_regs[i];
         w_busy_d[i] = r_busy[i];
         if (f_storable(ADDR_W'(i))) begin
            if (io_bus.link_en && ADDR_W'(i) == LinkAddr) begin
               w_regs_d[i] = io_bus.link_data;
            end else if (io_bus.wr_en && io_bus.wr_addr == ADDR_W'(i)) begin
               w_regs_d[i] = io_bus.wr_data;
            end
            // Flush beats reservation, reservation beats writeback clear.
            if (io_bus.flush) begin
               w_busy_d[i] = 1'b0;
            end else if (w_issue_ok && io_bus.issue_addr == ADDR_W'(i)) begin
               w_busy_d[i] = 1'b1;
            end else if (f_wr_hit(ADDR_W'(i), io_bus.wr_en, io_bus.wr_addr, io_bus.link_en)) begin
               w_busy_d[i] = 1'b0;
            end
         end
         w_busy_cnt_d = w_busy_cnt_d + CntW'(w_busy_d[i]);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= w_regs_d[i];
         end
         r_busy     <= w_busy_d;
         r_busy_cnt <= w_busy_cnt_d;
      end
   end

   assign io_bus.ra_data     = w_rd_data[0];
   assign io_bus.rb_data     = w_rd_data[1];
   assign io_bus.ra_busy     = w_rd_busy[0];
   assign io_bus.rb_busy     = w_rd_busy[1];
   assign io_bus.issue_ready = w_issue_ready;
   assign io_bus.busy_count  = r_busy_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic on two instances
// (16 regs / soft R0, and 12 regs / hardwired R0) against an array-based reference model.
module tb_regfile_scoreboard;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;
   localparam int unsigned CW = AW + 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          t_flush, t_ra_baout, t_rb_baout, t_wr_en, t_link_en, t_issue_valid;
   logic [AW-1:0] t_ra_addr, t_rb_addr, t_wr_addr, t_issue_addr;
   logic [DW-1:0] t_wr_data, t_link_data;

   logic [DW-1:0] o_ra_data [2];
   logic [DW-1:0] o_rb_data [2];
   logic          o_ra_busy [2];
   logic          o_rb_busy [2];
   logic          o_ready   [2];
   logic [CW-1:0] o_cnt     [2];

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] m_regs [2][16];
   bit            m_busy [2][16];

   regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
   regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

   regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(16), .ADDR_W(AW), .ZERO_MODE(1), .LINK_REG(15))
      dut_a (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_a));
   regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(12), .ADDR_W(AW), .ZERO_MODE(2), .LINK_REG(11))
      dut_b (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_b));

   assign bus_a.flush = t_flush;             assign bus_b.flush = t_flush;
   assign bus_a.ra_addr = t_ra_addr;         assign bus_b.ra_addr = t_ra_addr;
   assign bus_a.rb_addr = t_rb_addr;         assign bus_b.rb_addr = t_rb_addr;
   assign bus_a.ra_baout = t_ra_baout;       assign bus_b.ra_baout = t_ra_baout;
   assign bus_a.rb_baout = t_rb_baout;       assign bus_b.rb_baout = t_rb_baout;
   assign bus_a.wr_en = t_wr_en;             assign bus_b.wr_en = t_wr_en;
   assign bus_a.wr_addr = t_wr_addr;         assign bus_b.wr_addr = t_wr_addr;
   assign bus_a.wr_data = t_wr_data;         assign bus_b.wr_data = t_wr_data;
   assign bus_a.link_en = t_link_en;         assign bus_b.link_en = t_link_en;
   assign bus_a.link_data = t_link_data;     assign bus_b.link_data = t_link_data;
   assign bus_a.issue_valid = t_issue_valid; assign bus_b.issue_valid = t_issue_valid;
   assign bus_a.issue_addr = t_issue_addr;   assign bus_b.issue_addr = t_issue_addr;

   assign o_ra_data[0] = bus_a.ra_data;      assign o_ra_data[1] = bus_b.ra_data;
   assign o_rb_data[0] = bus_a.rb_data;      assign o_rb_data[1] = bus_b.rb_data;
   assign o_ra_busy[0] = bus_a.ra_busy;      assign o_ra_busy[1] = bus_b.ra_busy;
   assign o_rb_busy[0] = bus_a.rb_busy;      assign o_rb_busy[1] = bus_b.rb_busy;
   assign o_ready[0] = bus_a.issue_ready;    assign o_ready[1] = bus_b.issue_ready;
   assign o_cnt[0] = bus_a.busy_count;       assign o_cnt[1] = bus_b.busy_count;

   // ---------------- reference model ----------------
   function automatic int nregs(input int p); return (p == 0) ? 16 : 12; endfunction
   function automatic int zmode(input int p); return (p == 0) ? 1 : 2;   endfunction
   function automatic int link(input int p);  return (p == 0) ? 15 : 11; endfunction

   function automatic bit m_storable(input int p, input int a);
      return a < nregs(p) && !(zmode(p) == 2 && a == 0);
   endfunction

   function automatic bit m_written(input int p, input int a);
      return m_storable(p, a) &&
             ((t_wr_en && int'(t_wr_addr) == a) || (t_link_en && a == link(p)));
   endfunction

   function automatic bit m_zero(input int p, input int a, input bit baout);
      return a == 0 && (zmode(p) == 2 || (zmode(p) == 1 && baout));
   endfunction

   function automatic logic [DW-1:0] m_read(input int p, input int a, input bit baout);
      if (a >= nregs(p) || m_zero(p, a, baout)) return '0;
      if (t_link_en && a == link(p)) return t_link_data;
      if (t_wr_en && int'(t_wr_addr) == a) return t_wr_data;
      return m_regs[p][a];
   endfunction

   function automatic bit m_rbusy(input int p, input int a, input bit baout);
      if (a >= nregs(p) || m_zero(p, a, baout)) return 1'b0;
      return m_busy[p][a] && !m_written(p, a);
   endfunction

   function automatic bit m_ready(input int p);
      int a = int'(t_issue_addr);
      if (a >= nregs(p)) return 1'b1;
      return !m_busy[p][a] || m_written(p, a);
   endfunction

   function automatic int m_count(input int p);
      int n = 0;
      for (int a = 0; a < 16; a++) n += int'(m_busy[p][a]);
      return n;
   endfunction

   task automatic m_reset();
      for (int p = 0; p < 2; p++)
         for (int a = 0; a < 16; a++) begin
            m_regs[p][a] = '0;
            m_busy[p][a] = 1'b0;
         end
   endtask

   task automatic m_edge(input int p);
      bit iss = t_issue_valid && m_ready(p);
      int ia = int'(t_issue_addr);
      int wa = int'(t_wr_addr);
      for (int a = 0; a < 16; a++) if (m_written(p, a)) m_busy[p][a] = 1'b0;
      if (iss && m_storable(p, ia)) m_busy[p][ia] = 1'b1;
      if (t_flush) for (int a = 0; a < 16; a++) m_busy[p][a] = 1'b0;
      if (t_wr_en && m_storable(p, wa)) m_regs[p][wa] = t_wr_data;
      if (t_link_en && m_storable(p, link(p))) m_regs[p][link(p)] = t_link_data;
   endtask

   task automatic idle();
      t_flush = 0; t_ra_baout = 0; t_rb_baout = 0; t_wr_en = 0; t_link_en = 0;
      t_issue_valid = 0; t_ra_addr = '0; t_rb_addr = '0; t_wr_addr = '0; t_issue_addr = '0;
      t_wr_data = '0; t_link_data = '0;
   endtask

   task automatic tick();
      if (rst_n) begin
         m_edge(0);
         m_edge(1);
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      m_reset();
      #3;
      for (int a = 0; a < 16; a++) begin
         t_ra_addr = AW'(a);
         t_rb_addr = AW'(15 - a);
         t_ra_baout = a[0];
         #1;
         for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (o_ra_data[p] !== '0 || o_rb_data[p] !== '0) begin
               n_errors++;
               $display("FAIL reset_read dut%0d addr %0d: ra=%h rb=%h expected 0", p, a,
                        o_ra_data[p], o_rb_data[p]);
            end
         end
      end
      for (int p = 0; p < 2; p++) begin
         n_checks++;
         if (o_cnt[p] !== '0 || o_ready[p] !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_state dut%0d: busy_count=%0d issue_ready=%b expected 0/1", p,
                     o_cnt[p], o_ready[p]);
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
   endtask

   task automatic test_bypass();
      t_wr_en = 1; t_wr_addr = 4'd5; t_wr_data = 32'hDEADBEEF; t_ra_addr = 4'd5;
      #2;
      n_checks++;
      if (o_ra_data[0] !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL bypass_same_cycle: ra_data=%h expected deadbeef", o_ra_data[0]);
      end
      tick();
      idle(); t_ra_addr = 4'd5;
      #2;
      n_checks++;
      if (o_ra_data[0] !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL bypass_next_cycle: ra_data=%h expected deadbeef", o_ra_data[0]);
      end
      tick();
   endtask

   task automatic test_link();
      t_wr_en = 1; t_wr_addr = 4'd15; t_wr_data = 32'h11111111;
      t_link_en = 1; t_link_data = 32'h00000040; t_ra_addr = 4'd15;
      #2;
      n_checks++;
      if (o_ra_data[0] !== 32'h40) begin
         n_errors++;
         $display("FAIL link_bypass_wins: ra_data=%h expected 00000040", o_ra_data[0]);
      end
      tick();
      idle(); t_ra_addr = 4'd15;
      #2;
      n_checks++;
      if (o_ra_data[0] !== 32'h40) begin
         n_errors++;
         $display("FAIL link_commit_wins: R15=%h expected 00000040", o_ra_data[0]);
      end
      tick();
      t_wr_en = 1; t_wr_addr = 4'd3; t_wr_data = 32'h11111111;
      t_link_en = 1; t_link_data = 32'h00000040;
      tick();
      idle(); t_ra_addr = 4'd3; t_rb_addr = 4'd15;
      #2;
      n_checks++;
      if (o_ra_data[0] !== 32'h11111111 || o_rb_data[0] !== 32'h40) begin
         n_errors++;
         $display("FAIL dual_write: R3=%h R15=%h expected 11111111/00000040", o_ra_data[0],
                  o_rb_data[0]);
      end
      tick();
   endtask

   task automatic test_zero();
      t_wr_en = 1; t_wr_addr = 4'd0; t_wr_data = 32'h88; t_ra_addr = 4'd0;
      #2;
      n_checks++;
      if (o_ra_data[0] !== 32'h88 || o_ra_data[1] !== '0) begin
         n_errors++;
         $display("FAIL r0_bypass: mode1=%h mode2=%h expected 88/0", o_ra_data[0], o_ra_data[1]);
      end
      tick();
      idle(); t_ra_addr = 4'd0; t_rb_addr = 4'd0; t_rb_baout = 1;
      #2;
      n_checks++;
      if (o_ra_data[0] !== 32'h88 || o_rb_data[0] !== '0) begin
         n_errors++;
         $display("FAIL r0_mode1: baout0=%h baout1=%h expected 88/0", o_ra_data[0], o_rb_data[0]);
      end
      n_checks++;
      if (o_ra_data[1] !== '0 || o_rb_data[1] !== '0) begin
         n_errors++;
         $display("FAIL r0_mode2: ra=%h rb=%h expected 0/0", o_ra_data[1], o_rb_data[1]);
      end
      t_issue_valid = 1; t_issue_addr = 4'd0;
      tick();
      idle(); t_ra_addr = 4'd0; t_rb_addr = 4'd0; t_rb_baout = 1;
      #2;
      n_checks++;
      if (o_cnt[0] !== 5'd1 || o_cnt[1] !== 5'd0) begin
         n_errors++;
         $display("FAIL r0_reserve: counts=%0d/%0d expected 1/0", o_cnt[0], o_cnt[1]);
      end
      n_checks++;
      if (o_ra_busy[0] !== 1'b1 || o_rb_busy[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL r0_busy_mask: baout0=%b baout1=%b expected 1/0", o_ra_busy[0],
                  o_rb_busy[0]);
      end
      t_wr_en = 1; t_wr_addr = 4'd0; t_wr_data = 32'h88;
      tick();
      idle();
   endtask

   task automatic test_out_of_range();
      t_wr_en = 1; t_wr_addr = 4'd13; t_wr_data = 32'h1313; t_ra_addr = 4'd13;
      t_issue_valid = 1; t_issue_addr = 4'd13;
      #2;
      n_checks++;
      if (o_ra_data[0] !== 32'h1313 || o_ra_data[1] !== '0) begin
         n_errors++;
         $display("FAIL oor_read: 16reg=%h 12reg=%h expected 1313/0", o_ra_data[0], o_ra_data[1]);
      end
      tick();
      idle(); t_ra_addr = 4'd13; t_issue_addr = 4'd13;
      #2;
      n_checks++;
      if (o_cnt[0] !== 5'd1 || o_cnt[1] !== 5'd0 || o_ra_busy[0] !== 1'b1 || o_ready[1] !== 1'b1)
      begin
         n_errors++;
         $display("FAIL reserve_wins_oor: cnt=%0d/%0d busy=%b ready=%b expected 1/0 1 1",
                  o_cnt[0], o_cnt[1], o_ra_busy[0], o_ready[1]);
      end
      t_wr_en = 1; t_wr_addr = 4'd13; t_wr_data = 32'h1314;
      tick();
      idle();
   endtask

   task automatic test_scoreboard();
      t_issue_valid = 1; t_issue_addr = 4'd7;
      #2;
      n_checks++;
      if (o_ready[0] !== 1'b1 || o_cnt[0] !== 5'd0) begin
         n_errors++;
         $display("FAIL issue_idle: ready=%b cnt=%0d expected 1/0", o_ready[0], o_cnt[0]);
      end
      tick();
      idle(); t_ra_addr = 4'd7; t_issue_addr = 4'd7;
      #2;
      n_checks++;
      if (o_ra_busy[0] !== 1'b1 || o_ready[0] !== 1'b0 || o_cnt[0] !== 5'd1) begin
         n_errors++;
         $display("FAIL busy_set: ra_busy=%b ready=%b cnt=%0d expected 1/0/1", o_ra_busy[0],
                  o_ready[0], o_cnt[0]);
      end
      t_wr_en = 1; t_wr_addr = 4'd7; t_wr_data = 32'h25;
      #2;
      n_checks++;
      if (o_ra_busy[0] !== 1'b0 || o_ra_data[0] !== 32'h25 || o_ready[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL writeback_hide: ra_busy=%b data=%h ready=%b expected 0/25/1",
                  o_ra_busy[0], o_ra_data[0], o_ready[0]);
      end
      tick();
      idle();
      #2;
      n_checks++;
      if (o_cnt[0] !== 5'd0) begin
         n_errors++;
         $display("FAIL busy_clear: cnt=%0d expected 0", o_cnt[0]);
      end
      tick();
   endtask

   task automatic test_flush();
      t_wr_en = 1; t_wr_addr = 4'd2; t_wr_data = 32'h2222;
      tick();
      t_wr_addr = 4'd9; t_wr_data = 32'h9999;
      tick();
      idle(); t_issue_valid = 1; t_issue_addr = 4'd2;
      tick();
      t_issue_addr = 4'd9;
      tick();
      idle();
      #2;
      n_checks++;
      if (o_cnt[0] !== 5'd2) begin
         n_errors++;
         $display("FAIL two_busy: cnt=%0d expected 2", o_cnt[0]);
      end
      t_flush = 1; t_issue_valid = 1; t_issue_addr = 4'd4;
      tick();
      idle(); t_ra_addr = 4'd2; t_rb_addr = 4'd9;
      #2;
      n_checks++;
      if (o_cnt[0] !== 5'd0 || o_ra_busy[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_busy: cnt=%0d ra_busy=%b expected 0/0", o_cnt[0], o_ra_busy[0]);
      end
      n_checks++;
      if (o_ra_data[0] !== 32'h2222 || o_rb_data[0] !== 32'h9999) begin
         n_errors++;
         $display("FAIL flush_data: R2=%h R9=%h expected 2222/9999", o_ra_data[0], o_rb_data[0]);
      end
      t_issue_valid = 1; t_issue_addr = 4'd6;
      tick();
      idle(); t_ra_addr = 4'd2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (o_cnt[0] !== 5'd0 || o_ra_data[0] !== '0) begin
         n_errors++;
         $display("FAIL async_reset: cnt=%0d R2=%h expected 0/0", o_cnt[0], o_ra_data[0]);
      end
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         t_ra_addr = AW'($urandom_range(15));
         t_rb_addr = AW'($urandom_range(15));
         t_ra_baout = 1'($urandom_range(1));
         t_rb_baout = 1'($urandom_range(1));
         t_wr_en = 1'($urandom_range(1));
         t_wr_addr = AW'($urandom_range(15));
         t_wr_data = $urandom;
         t_link_en = ($urandom_range(3) == 0);
         t_link_data = $urandom;
         t_issue_valid = 1'($urandom_range(1));
         t_issue_addr = AW'($urandom_range(15));
         t_flush = ($urandom_range(15) == 0);
         #2;
         for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (o_ra_data[p] !== m_read(p, int'(t_ra_addr), t_ra_baout) ||
                o_rb_data[p] !== m_read(p, int'(t_rb_addr), t_rb_baout)) begin
               n_errors++;
               $display("FAIL rand_data dut%0d cyc %0d: ra=%h/%h rb=%h/%h (got/expected)", p, c,
                        o_ra_data[p], m_read(p, int'(t_ra_addr), t_ra_baout),
                        o_rb_data[p], m_read(p, int'(t_rb_addr), t_rb_baout));
            end
            n_checks++;
            if (o_ra_busy[p] !== m_rbusy(p, int'(t_ra_addr), t_ra_baout) ||
                o_rb_busy[p] !== m_rbusy(p, int'(t_rb_addr), t_rb_baout)) begin
               n_errors++;
               $display("FAIL rand_busy dut%0d cyc %0d: ra=%b/%b rb=%b/%b (got/expected)", p, c,
                        o_ra_busy[p], m_rbusy(p, int'(t_ra_addr), t_ra_baout),
                        o_rb_busy[p], m_rbusy(p, int'(t_rb_addr), t_rb_baout));
            end
            n_checks++;
            if (o_ready[p] !== m_ready(p) || o_cnt[p] !== CW'(m_count(p))) begin
               n_errors++;
               $display("FAIL rand_sb dut%0d cyc %0d: ready=%b/%b cnt=%0d/%0d (got/expected)", p,
                        c, o_ready[p], m_ready(p), o_cnt[p], m_count(p));
            end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_link();
      test_zero();
      test_out_of_range();
      test_scoreboard();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
